// File: rtl/conv_encoder_punct.sv
// Rate-1/2, K=3 convolutional encoder (generators 7/5 octal) with frame tail
// termination and optional puncturing; erased and idle parity bits float to z.
module conv_encoder_punct #(
    parameter int         FRAME_LEN     = 8,
    parameter int         PUNCT_EN      = 1,
    parameter int         PUNCT_PERIOD  = 2,
    parameter logic [7:0] PUNCT_PATTERN = 8'b0000_10_11
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] parities,
    output logic [1:0] erase,
    output logic       dout_valid,
    output logic       busy,
    output logic       frame_done
);

    localparam int            CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);
    localparam logic [1:0]    LAST_STEP = 2'(PUNCT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sr_q, sr_n;          // {u1,u2}
    logic [CW-1:0] cnt_q, cnt_n;
    logic [1:0]    step_q, step_n;
    logic          tail2_q, tail2_n;
    logic [1:0]    data_q, data_n;
    logic [1:0]    erase_q, erase_n;
    logic          valid_q, valid_n;
    logic          done_q, done_n;
    logic          ready_q, busy_q;
    logic          emit;
    logic          u;
    logic [1:0]    keep;

    always_comb begin
        state_n = state;
        sr_n    = sr_q;
        cnt_n   = cnt_q;
        step_n  = step_q;
        tail2_n = tail2_q;
        data_n  = 2'b00;
        erase_n = 2'b11;
        valid_n = 1'b0;
        done_n  = 1'b0;
        emit    = 1'b0;
        u       = 1'b0;
        // An all-erase mask would lose the symbol entirely, so it keeps both bits.
        keep    = PUNCT_PATTERN[{step_q, 1'b0} +: 2];
        if (keep == 2'b00) keep = 2'b11;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    step_n  = 2'b00;
                    tail2_n = 1'b0;
                end
            end
            S_DATA: begin
                if (din_valid) begin
                    emit  = 1'b1;
                    u     = din;
                    cnt_n = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) state_n = S_TAIL;
                end
            end
            S_TAIL: begin
                emit    = 1'b1;
                tail2_n = 1'b1;
                if (tail2_q) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    tail2_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (emit) begin
            data_n  = {u ^ sr_q[1] ^ sr_q[0], u ^ sr_q[0]};
            sr_n    = {u, sr_q[1]};
            valid_n = 1'b1;
            erase_n = (PUNCT_EN != 0) ? ~keep : 2'b00;
            step_n  = (step_q == LAST_STEP) ? 2'b00 : step_q + 2'b01;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            sr_q    <= 2'b00;
            cnt_q   <= '0;
            step_q  <= 2'b00;
            tail2_q <= 1'b0;
            data_q  <= 2'b00;
            erase_q <= 2'b11;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            sr_q    <= sr_n;
            cnt_q   <= cnt_n;
            step_q  <= step_n;
            tail2_q <= tail2_n;
            data_q  <= data_n;
            erase_q <= erase_n;
            valid_q <= valid_n;
            done_q  <= done_n;
            ready_q <= (state_n == S_DATA);
            busy_q  <= (state_n != S_IDLE);
        end
    end

    // Erased bits float so the decoder sees them as erasures.
    assign parities[1] = erase_q[1] ? 1'bz : data_q[1];
    assign parities[0] = erase_q[0] ? 1'bz : data_q[0];
    assign erase       = erase_q;
    assign dout_valid  = valid_q;
    assign frame_done  = done_q;
    assign din_ready   = ready_q;
    assign busy        = busy_q;

endmodule

// File: doc/conv_encoder_punct.md
Name: conv_encoder_punct

Overview:
Frame-based rate-1/2, K=3 convolutional encoder with optional puncturing. It sits directly upstream of the Viterbi decoder stage and drives that stage's 2-bit parity input every CLK.
- Generators: MSB = 7 octal, i.e. p1 = u^u1^u2. LSB = 5 octal, i.e. p0 = u^u2.
- Each frame ends with 2 zero tail bits, which returns the trellis to state 00.
- Punctured bits and bubble cycles are driven as 1'bz. The decoder takes a single-z symbol as an erasure and holds its state on 2'bzz.

Parameters:
FRAME_LEN, 8, number of data bits per frame (>=1).
PUNCT_EN, 1, 1 = apply PUNCT_PATTERN; 0 = rate 1/2, no erasures.
PUNCT_PERIOD, 2, puncture period in symbols (1..4).
PUNCT_PATTERN, 8'b0000_10_11, keep mask for step k at bits [2k+1:2k] as {keep_p1,keep_p0}. Default gives rate 2/3.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  synchronous active-low reset.
start  input  1  frame start request; sampled only in IDLE.
din  input  1  data bit.
din_valid  input  1  din valid.
din_ready  output  1  encoder accepts din this cycle.
parities  output  2  coded symbol to decoder; erased or bubble bits = 1'bz.
erase  output  2  per-bit erasure flags; 1 = bit is z.
dout_valid  output  1  parities carries a coded symbol.
busy  output  1  FSM not in IDLE.
frame_done  output  1  1-cycle pulse coincident with last tail symbol.

Behaviour:
- Reset (RST_N=0 at CLK edge) forces the following, whether idle or mid-frame:
  - FSM = IDLE; shift register {u1,u2} = 00; bit count = 0; puncture step = 0.
  - erase = 11, parities = zz, dout_valid = 0, din_ready = 0, busy = 0, frame_done = 0.
- parities is a combinational z-mux of registered data and erase: bit i = 1'bz when erase[i]=1, else data bit i. All other outputs are registered.
- FSM states:
  - IDLE: din_ready=0. start=1 -> DATA next cycle; bit count and puncture step cleared.
  - DATA: din_ready=1.
    - Accept when din_valid & din_ready: compute (p1,p0) from din,u1,u2, then shift {u1,u2} <= {din,u1}.
    - If count+1 == FRAME_LEN -> TAIL.
    - No valid in a cycle -> bubble next cycle: erase=11, dout_valid=0, no state change, puncture step not advanced.
  - TAIL: din_ready=0, 2 cycles. Encodes u=0 unconditionally, no handshake.
    - 2nd tail cycle -> IDLE; frame_done=1 in the output cycle of the 2nd tail symbol.
- Latency: symbol for an accepted bit (or tail bit) appears on parities/dout_valid/erase in the next cycle.
- Symbol output cycle: dout_valid=1.
  - erase = ~keep[step] when PUNCT_EN=1, else 00.
  - A step whose keep mask is 00 is treated as 11, so at most one erasure per symbol.
  - step increments per emitted symbol (data or tail) and wraps PUNCT_PERIOD-1 -> 0.
  - step restarts at 0 each frame.
- Non-symbol cycles (idle, bubble, after frame end): erase=11, parities=zz, dout_valid=0.
- Bit counter width is $clog2(FRAME_LEN+1). No wrap within a frame.
- start outside IDLE is ignored. start in the cycle after frame_done begins a new frame; back-to-back frames have a single zz gap.
- busy=1 in DATA and TAIL.
- Trellis is 00 at frame end and after reset, so it matches the decoder's reset state.

Test Plan:
1. PUNCT_EN=0, FRAME_LEN=4, din 1,0,1,1 streamed with no gaps -> parities 11,10,00,01 then tail 01,11. frame_done with the final 11. dout_valid high for 6 cycles. Then zz.
2. Default puncturing, same stimulus -> parities 11,1z,00,0z,01,1z. erase 00,01,00,01,00,01.
3. Case 1 with din_valid low for 2 cycles after the 2nd bit -> two zz bubbles (dout_valid=0, erase=11) inserted. Coded sequence unchanged. Puncture step not advanced during bubbles.
4. RST_N=0 after 3rd accepted bit -> next cycle: busy=0, parities=zz, din_ready=0. A new start re-encodes from state 00 (first bit 1 -> 11).
5. start asserted during DATA and TAIL -> ignored. start on cycle after frame_done -> new frame, first symbol 2 cycles later.
6. Loopback through the decoder with random 32-bit frames, both PUNCT_EN values -> decoded bits equal din, and tail decodes 0,0.
